inv_shift128_rx: RTL

Receive-side inverse ShiftRows unit for the AES datapath. It accepts a byte stream over a valid/ready handshake and packs each 16-byte block into a 128-bit AES state. It applies InvShiftRows to the state and presents the result over a 128-bit valid/ready output. It is the decrypt/receive counterpart of the transmit-side ShiftRows stage. It also checks block framing through an end-of-block marker.

---
 rtl/inv_shift128_rx.sv | 101 ++++++++++
 1 files changed

// File: rtl/inv_shift128_rx.sv
// inv_shift128_rx: packs a framed 16-byte receive stream into a 128-bit AES
// state, applies InvShiftRows and holds the result behind a valid/ready
// output register. Framing errors (early or missing end marker) drop the
// block and raise a one-cycle err pulse.
module inv_shift128_rx (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err
);

    logic [119:0] asm_q, asm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         err_q, err_d;

    logic         accept;
    logic         at_last_slot;
    logic         drain;

    // Byte k of the state sits at [127-8k -: 8]; out(r,c) = in(r, (c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    assign at_last_slot = (cnt_q == 4'd15);
    // Only the 16th byte can stall: it needs the output register to be free.
    assign in_ready     = !at_last_slot || !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign drain        = out_valid_q && out_ready;

    // Next-state: byte assembly, framing checks and output register update.
    always_comb begin
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = drain ? 1'b0 : out_valid_q;
        err_d       = 1'b0;

        if (accept) begin
            if (!at_last_slot) begin
                for (int unsigned k = 0; k < 15; k++) begin
                    if (cnt_q == 4'(k)) begin
                        asm_d[119 - 8*k -: 8] = in_data;
                    end
                end
                if (in_last) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = '0;
                if (in_last) begin
                    // A load on the same edge as a drain keeps out_valid high.
                    out_data_d  = inv_shift_rows({asm_q, in_data});
                    out_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule
